// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
//
// 8N1 UART receive path. The asynchronous rx line is brought into the clk_50m
// domain through a small synchronizer. An oversampling state machine then finds
// the start bit and samples each data bit and the stop bit near its centre.
// Each correctly framed byte is presented on `data` together with a ready flag.
//
// Ports
//   clk_50m     in   system clock, all logic on the rising edge
//   rst_n       in   asynchronous active-low reset
//   rx          in   asynchronous serial line, idle high
//   clken       in   1-cycle enable pulse at OVERSAMPLE x baud
//   rdy_clr     in   acknowledge; clears rdy and overrun_err
//   data[7:0]   out  last correctly framed byte
//   rdy         out  an unacknowledged byte is held in data
//   frame_err   out  the last completed frame had a bad stop bit
//   overrun_err out  sticky; a good byte arrived while rdy was still high
//   rx_busy     out  state machine is not idle
// -----------------------------------------------------------------------------
module uart_receiver #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_50m,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       clken,
  input  logic       rdy_clr,
  output logic [7:0] data,
  output logic       rdy,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       rx_busy
);

  localparam int SAMPLE_W = $clog2(OVERSAMPLE);

  // Tick count at the centre of the start bit, measured from the detected edge.
  localparam logic [SAMPLE_W-1:0] MID_START = SAMPLE_W'(OVERSAMPLE / 2 - 1);
  // Tick count of one full bit period, measured from the previous sample point.
  localparam logic [SAMPLE_W-1:0] LAST_TICK = SAMPLE_W'(OVERSAMPLE - 1);
  localparam logic [SAMPLE_W-1:0] SAMPLE_ONE = SAMPLE_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t                 state_q,     state_d;
  logic [SYNC_STAGES-1:0] sync_q,      sync_d;
  logic [SAMPLE_W-1:0]    sample_q,    sample_d;
  logic [2:0]             bitpos_q,    bitpos_d;
  logic [7:0]             shift_q,     shift_d;
  logic                   armed_q,     armed_d;
  logic [7:0]             data_q,      data_d;
  logic                   rdy_q,       rdy_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q,   overrun_d;

  logic rx_s;
  logic good_frame;
  logic bad_frame;

  // Synchronizer shift: rx enters at bit 0 and leaves at the top stage.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], rx};
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  // Synchronizer flops; preset to the idle-high line level.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{1'b1}};
    end else begin
      sync_q <= sync_d;
    end
  end

  // Receive state machine: next state, counters and shift register.
  always_comb begin
    state_d    = state_q;
    sample_d   = sample_q;
    bitpos_d   = bitpos_q;
    shift_d    = shift_q;
    armed_d    = armed_q;
    good_frame = 1'b0;
    bad_frame  = 1'b0;

    if (clken) begin
      case (state_q)
        ST_IDLE: begin
          // A start edge only counts once the line has been seen high, so a
          // held-low line (break) cannot launch frame after frame.
          if (armed_q && !rx_s) begin
            state_d  = ST_START;
            sample_d = '0;
            armed_d  = 1'b0;
          end else if (rx_s) begin
            armed_d = 1'b1;
          end else begin
            armed_d = armed_q;
          end
        end

        ST_START: begin
          if (sample_q == MID_START) begin
            sample_d = '0;
            if (!rx_s) begin
              state_d  = ST_DATA;
              bitpos_d = 3'd0;
            end else begin
              // Line went back high before mid start bit: noise, not a frame.
              state_d = ST_IDLE;
              armed_d = 1'b0;
            end
          end else begin
            sample_d = sample_q + SAMPLE_ONE;
          end
        end

        ST_DATA: begin
          if (sample_q == LAST_TICK) begin
            sample_d          = '0;
            shift_d[bitpos_q] = rx_s;
            if (bitpos_q == 3'd7) begin
              state_d  = ST_STOP;
              bitpos_d = 3'd0;
            end else begin
              bitpos_d = bitpos_q + 3'd1;
            end
          end else begin
            sample_d = sample_q + SAMPLE_ONE;
          end
        end

        ST_STOP: begin
          if (sample_q == LAST_TICK) begin
            sample_d = '0;
            state_d  = ST_IDLE;
            armed_d  = 1'b0;
            if (rx_s) begin
              good_frame = 1'b1;
            end else begin
              bad_frame = 1'b1;
            end
          end else begin
            sample_d = sample_q + SAMPLE_ONE;
          end
        end

        default: begin
          state_d  = ST_IDLE;
          sample_d = '0;
          bitpos_d = 3'd0;
          armed_d  = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Receive state machine registers.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sample_q <= '0;
      bitpos_q <= 3'd0;
      shift_q  <= 8'h00;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      bitpos_q <= bitpos_d;
      shift_q  <= shift_d;
      armed_q  <= armed_d;
    end
  end

  // Output flags: acknowledge clears, a good-frame commit then overrides it.
  always_comb begin
    data_d      = data_q;
    rdy_d       = rdy_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;

    if (rdy_clr) begin
      rdy_d     = 1'b0;
      overrun_d = 1'b0;
    end else begin
      rdy_d     = rdy_q;
      overrun_d = overrun_q;
    end

    if (good_frame) begin
      data_d      = shift_q;
      rdy_d       = 1'b1;
      frame_err_d = 1'b0;
      // Overrun only if the previous byte is still pending and not being
      // acknowledged in this very cycle.
      if (rdy_q && !rdy_clr) begin
        overrun_d = 1'b1;
      end else begin
        overrun_d = overrun_d;
      end
    end else if (bad_frame) begin
      frame_err_d = 1'b1;
    end else begin
      frame_err_d = frame_err_q;
    end
  end

  // Output flag registers.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      data_q      <= 8'h00;
      rdy_q       <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      data_q      <= data_d;
      rdy_q       <= rdy_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign data        = data_q;
  assign rdy         = rdy_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_q;
  assign rx_busy     = (state_q != ST_IDLE);

endmodule
